cop_issue: RTL and testbench
============================

Name: cop_issue

Overview:
- Core-side initiator for the custom-coprocessor interface: cop_valid/cop_ready/cop_wait/cop_wr, cop_insn/cop_rs1/cop_rs2/cop_rd.
- Accepts one instruction from the pipeline over a valid/ready request port and drives it onto the coprocessor bus, holding it stable until the coprocessor's cop_ready pulse.
- Captures cop_rd/cop_wr and returns them on a valid/ready response port.
- Guards against unresponsive coprocessors with a watchdog. Sits between the core's execute stage and the cop_* responder.

Parameters:
- CUSOPCODE, 7'b0001011: opcode routed to the coprocessor; any other opcode is rejected locally.
- TOW, 10: width of the watchdog counter.
- TIMEOUT, 10'd1000: cycles cop_valid may stay high without cop_ready before abort; must be ≥1.

Ports:
- cop_clk, in, 1: clock.
- cop_rst_n, in, 1: reset, asynchronous, active-low.
- req_valid, in, 1: request valid.
- req_ready, out, 1: request accepted when req_valid && req_ready.
- req_insn, in, 32: instruction word.
- req_rs1, in, 32: source operand 1.
- req_rs2, in, 32: source operand 2.
- rsp_valid, out, 1: response valid.
- rsp_ready, in, 1: response consumed.
- rsp_data, out, 32: captured cop_rd.
- rsp_wr, out, 1: captured cop_wr.
- rsp_err, out, 2: 00 ok, 01 timeout, 10 bad opcode.
- rsp_cycles, out, 16: count of cycles cop_valid was high for this op, saturating.
- cop_valid, out, 1: request to coprocessor.
- cop_insn, out, 32: instruction to coprocessor.
- cop_rs1, out, 32: operand 1 to coprocessor.
- cop_rs2, out, 32: operand 2 to coprocessor.
- cop_ready, in, 1: one-cycle completion pulse.
- cop_wait, in, 1: coprocessor stalling; informational only.
- cop_wr, in, 1: result writes rd.
- cop_rd, in, 32: result.
- busy, out, 1: state != IDLE.

Behaviour:
- Reset (cop_rst_n low, asynchronous): state IDLE; cop_valid, rsp_valid, busy = 0; cop_insn/rs1/rs2, rsp_data, rsp_cycles, rsp_err, rsp_wr = 0; watchdog = 0.
- Reset asserted mid-operation abandons the op with no response; cop_valid falls immediately, not at the next edge.
- All outputs are registered. req_ready = (state == IDLE).
- State machine, three states:
  - IDLE:
    - On request accept with req_insn[6:0] == CUSOPCODE: latch insn/rs1/rs2 onto cop_insn/cop_rs1/cop_rs2, set cop_valid = 1, clear watchdog, set rsp_cycles = 0, go to ISSUE.
    - On accept with any other opcode: no bus activity; rsp_err = 10, rsp_data = 0, rsp_wr = 0, rsp_cycles = 0, go to RESP.
  - ISSUE:
    - Each cycle, rsp_cycles increments (saturating at 16'hFFFF) and the watchdog increments.
    - If cop_ready = 1: rsp_data = cop_rd, rsp_wr = cop_wr, rsp_err = 00, cop_valid = 0 at that edge, go to RESP.
    - Otherwise, if watchdog == TIMEOUT-1: rsp_err = 01, rsp_data = 0, rsp_wr = 0, cop_valid = 0, go to RESP.
    - If cop_ready and timeout occur in the same cycle, cop_ready wins.
  - RESP: rsp_valid = 1, with rsp_* held stable until rsp_ready; on handshake, rsp_valid = 0 and go to IDLE.
- Bus rules:
  - cop_insn/cop_rs1/cop_rs2 are constant for the entire cycle span in which cop_valid is high; the responder decodes cop_insn combinationally and samples cop_rs2 late.
  - cop_valid deasserts on the edge that samples cop_ready, so the responder's return to idle never sees a stale valid.
  - cop_ready outside ISSUE (late pulse after a timeout) is ignored.
  - cop_wait has no effect on control.
- Latency, request accepted at edge N:
  - cop_valid is high from cycle N+1.
  - Against a zero-delay arithmetic responder, cop_ready arrives in cycle N+5, rsp_valid rises at N+6, and rsp_cycles = 5.
  - For rdrand (funct[2:0] = 010), cop_ready arrives at N+3 and rsp_cycles = 3.
- Throughput: one outstanding op; the next request is accepted only in the cycle after the response handshake.

Optional Feature:
COP_ISSUE_STATS_EN:
- When defined, adds outputs stat_ops (16), stat_tmo (16) and stat_wait (16).
- All three are saturating counters and reset to 0.
  - stat_ops: completed ok ops.
  - stat_tmo: timeouts.
  - stat_wait: cycles with cop_wait = 1 while in ISSUE.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- xori, insn 0x0C00000B, rs1 0x12345678, rs2 0x0F0F0F0F, timing randomisation off -> cop_valid high 5 cycles; rsp_data 0x1D3B5977, rsp_wr 1, rsp_err 00, rsp_cycles 5.
- addi, insn 0x0800000B, rs1 0xFFFFFFFF, rs2 0x00000002 -> rsp_data 0x00000001, rsp_err 00; cop_insn/rs1/rs2 unchanged every cycle cop_valid is high.
- Bad opcode, insn 0x0C000033 -> cop_valid never rises; rsp_valid one cycle after accept with rsp_err 10, rsp_cycles 0.
- TIMEOUT=16, stub never asserts cop_ready -> cop_valid high exactly 16 cycles, then rsp_err 01, rsp_data 0; a cop_ready pulse 3 cycles later is ignored and the next op completes normally.
- rsp_ready held low 10 cycles after completion, with req_valid high -> rsp_* stable, req_ready 0, cop_valid 0; the next request is accepted in the cycle after the rsp handshake.
- cop_rst_n driven low mid-ISSUE, between edges -> cop_valid, busy, rsp_valid go 0 immediately; after release, req_ready is 1 and no response is produced for the aborted op.

Source files
------------

// File: rtl/cop_issue.sv
// cop_issue: core-side initiator for the custom-coprocessor bus.
//
// Takes one instruction at a time from the execute stage (req_*), drives it
// onto the coprocessor bus (cop_*) and holds it stable until the one-cycle
// cop_ready completion pulse. The result (cop_rd/cop_wr) is then returned on
// the response port (rsp_*). A watchdog aborts the op if the coprocessor
// never answers. Instructions whose opcode is not CUSOPCODE never reach the
// bus and are answered locally with a bad-opcode error.
//
// Handshakes: a transfer happens on a rising cop_clk edge where valid and
// ready are both high; a valid side holds its payload stable and keeps valid
// high until that edge.
//
// Ports:
//   cop_clk, cop_rst_n        clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake; req_ready = (state == IDLE)
//   req_insn/req_rs1/req_rs2  instruction word and source operands
//   rsp_valid/rsp_ready       response handshake
//   rsp_data/rsp_wr           captured cop_rd / cop_wr
//   rsp_err                   00 ok, 01 timeout, 10 bad opcode
//   rsp_cycles                cycles cop_valid was high for this op (saturating)
//   cop_valid, cop_insn, cop_rs1, cop_rs2   request to coprocessor
//   cop_ready, cop_wr, cop_rd               completion pulse and result
//   cop_wait                  coprocessor stalling, informational only
//   busy                      state != IDLE
//   state                     current FSM state (debug)
//
// Optional feature macro COP_ISSUE_STATS_EN: adds saturating counters
//   stat_ops (completed ok ops), stat_tmo (timeouts) and stat_wait (ISSUE
//   cycles with cop_wait high).

module cop_issue #(
  parameter logic [6:0]     CUSOPCODE = 7'b0001011,
  parameter int             TOW       = 10,
  parameter logic [TOW-1:0] TIMEOUT   = 10'd1000
) (
  input  logic        cop_clk,
  input  logic        cop_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_wr,
  output logic [1:0]  rsp_err,
  output logic [15:0] rsp_cycles,
  output logic        cop_valid,
  output logic [31:0] cop_insn,
  output logic [31:0] cop_rs1,
  output logic [31:0] cop_rs2,
  input  logic        cop_ready,
  input  logic        cop_wait,
  input  logic        cop_wr,
  input  logic [31:0] cop_rd,
`ifdef COP_ISSUE_STATS_EN
  output logic [15:0] stat_ops,
  output logic [15:0] stat_tmo,
  output logic [15:0] stat_wait,
`endif
  output logic        busy,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [1:0]     ERR_OK  = 2'b00;
  localparam logic [1:0]     ERR_TMO = 2'b01;
  localparam logic [1:0]     ERR_OPC = 2'b10;
  localparam logic [TOW-1:0] WD_LAST = TIMEOUT - {{(TOW-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic           cop_valid_q, cop_valid_d;
  logic [31:0]    cop_insn_q, cop_insn_d;
  logic [31:0]    cop_rs1_q, cop_rs1_d;
  logic [31:0]    cop_rs2_q, cop_rs2_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic           rsp_wr_q, rsp_wr_d;
  logic [1:0]     rsp_err_q, rsp_err_d;
  logic [15:0]    rsp_cycles_q, rsp_cycles_d;
  logic [TOW-1:0] wd_q, wd_d;

  // Completion and timeout events, only meaningful in ISSUE. cop_ready has
  // priority, so a timeout only counts when no completion arrives.
  logic op_done, op_tmo;
  assign op_done = (state_q == S_ISSUE) && cop_ready;
  assign op_tmo  = (state_q == S_ISSUE) && !cop_ready && (wd_q == WD_LAST);

  always_ff @(posedge cop_clk or negedge cop_rst_n) begin
    if (!cop_rst_n) begin
      state_q      <= S_IDLE;
      cop_valid_q  <= 1'b0;
      cop_insn_q   <= '0;
      cop_rs1_q    <= '0;
      cop_rs2_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_wr_q     <= 1'b0;
      rsp_err_q    <= ERR_OK;
      rsp_cycles_q <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      cop_valid_q  <= cop_valid_d;
      cop_insn_q   <= cop_insn_d;
      cop_rs1_q    <= cop_rs1_d;
      cop_rs2_q    <= cop_rs2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_err_q    <= rsp_err_d;
      rsp_cycles_q <= rsp_cycles_d;
      wd_q         <= wd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cop_valid_d  = cop_valid_q;
    cop_insn_d   = cop_insn_q;
    cop_rs1_d    = cop_rs1_q;
    cop_rs2_d    = cop_rs2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_wr_d     = rsp_wr_q;
    rsp_err_d    = rsp_err_q;
    rsp_cycles_d = rsp_cycles_q;
    wd_d         = wd_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rsp_cycles_d = '0;
          if (req_insn[6:0] == CUSOPCODE) begin
            cop_insn_d  = req_insn;
            cop_rs1_d   = req_rs1;
            cop_rs2_d   = req_rs2;
            cop_valid_d = 1'b1;
            wd_d        = '0;
            state_d     = S_ISSUE;
          end else begin
            rsp_err_d   = ERR_OPC;
            rsp_data_d  = '0;
            rsp_wr_d    = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        // cop_valid was high during this cycle, so it counts toward the op.
        if (rsp_cycles_q != 16'hFFFF) rsp_cycles_d = rsp_cycles_q + 16'd1;
        wd_d = wd_q + {{(TOW-1){1'b0}}, 1'b1};
        if (op_done) begin
          rsp_data_d  = cop_rd;
          rsp_wr_d    = cop_wr;
          rsp_err_d   = ERR_OK;
          cop_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (op_tmo) begin
          rsp_data_d  = '0;
          rsp_wr_d    = 1'b0;
          rsp_err_d   = ERR_TMO;
          cop_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        cop_valid_d = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign state      = state_q;
  assign cop_valid  = cop_valid_q;
  assign cop_insn   = cop_insn_q;
  assign cop_rs1    = cop_rs1_q;
  assign cop_rs2    = cop_rs2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_wr     = rsp_wr_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_cycles = rsp_cycles_q;

`ifdef COP_ISSUE_STATS_EN
  logic [15:0] stat_ops_q, stat_tmo_q, stat_wait_q;

  always_ff @(posedge cop_clk or negedge cop_rst_n) begin
    if (!cop_rst_n) begin
      stat_ops_q  <= '0;
      stat_tmo_q  <= '0;
      stat_wait_q <= '0;
    end else begin
      if (op_done && stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
      if (op_tmo && stat_tmo_q != 16'hFFFF) stat_tmo_q <= stat_tmo_q + 16'd1;
      if ((state_q == S_ISSUE) && cop_wait && stat_wait_q != 16'hFFFF)
        stat_wait_q <= stat_wait_q + 16'd1;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_tmo  = stat_tmo_q;
  assign stat_wait = stat_wait_q;
`else
  // cop_wait only feeds the statistics counters.
  logic unused_cop_wait;
  assign unused_cop_wait = cop_wait;
`endif

endmodule

// File: tb/tb_cop_issue.sv
// Directed testbench for cop_issue with TIMEOUT shortened to 16. The bench
// plays the coprocessor itself, pulsing cop_ready with hand-computed results.
// Inputs change and outputs are checked 1 time unit after each rising edge.

module tb_cop_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_insn, req_rs1, req_rs2;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_wr;
  logic [1:0]  rsp_err;
  logic [15:0] rsp_cycles;
  logic        cop_valid;
  logic [31:0] cop_insn, cop_rs1, cop_rs2;
  logic        cop_ready, cop_wait, cop_wr;
  logic [31:0] cop_rd;
  logic        busy;
  logic [1:0]  state;
`ifdef COP_ISSUE_STATS_EN
  logic [15:0] stat_ops, stat_tmo, stat_wait;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cop_issue #(
    .CUSOPCODE(7'b0001011),
    .TOW(10),
    .TIMEOUT(10'd16)
  ) dut (
    .cop_clk(clk), .cop_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_wr(rsp_wr), .rsp_err(rsp_err),
    .rsp_cycles(rsp_cycles),
    .cop_valid(cop_valid), .cop_insn(cop_insn),
    .cop_rs1(cop_rs1), .cop_rs2(cop_rs2),
    .cop_ready(cop_ready), .cop_wait(cop_wait),
    .cop_wr(cop_wr), .cop_rd(cop_rd),
`ifdef COP_ISSUE_STATS_EN
    .stat_ops(stat_ops), .stat_tmo(stat_tmo), .stat_wait(stat_wait),
`endif
    .busy(busy), .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, answer it after lat cycles with (rd, wr), check the bus
  // stays stable while cop_valid is high, and check the registered response.
  task automatic do_op(input string tag, input logic [31:0] insn, input logic [31:0] rs1,
                       input logic [31:0] rs2, input int lat,
                       input logic [31:0] rd, input logic wr);
    chk({tag, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_insn = insn; req_rs1 = rs1; req_rs2 = rs2;
    tick();
    req_valid = 1'b0;
    req_insn  = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
    for (int k = 1; k <= lat; k++) begin
      chk({tag, "_cop_valid"}, cop_valid, 1);
      chk({tag, "_cop_insn"}, cop_insn, insn);
      chk({tag, "_cop_rs1"}, cop_rs1, rs1);
      chk({tag, "_cop_rs2"}, cop_rs2, rs2);
      chk({tag, "_rsp_valid_low"}, rsp_valid, 0);
      cop_rd   = $urandom;
      cop_wr   = 1'($urandom_range(0, 1));
      cop_wait = 1'($urandom_range(0, 1));
      if (k == lat) begin
        cop_ready = 1'b1; cop_rd = rd; cop_wr = wr;
      end
      tick();
    end
    cop_ready = 1'b0; cop_wait = 1'b0; cop_rd = 32'hBAD0_BAD0;
    chk({tag, "_cop_valid_off"}, cop_valid, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_data"}, rsp_data, rd);
    chk({tag, "_rsp_wr"}, rsp_wr, wr);
    chk({tag, "_rsp_err"}, rsp_err, 2'b00);
    chk({tag, "_rsp_cycles"}, rsp_cycles, lat);
  endtask

  task automatic rsp_handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_clr"}, rsp_valid, 0);
    chk({tag, "_req_ready_back"}, req_ready, 1);
    chk({tag, "_busy_clr"}, busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
    rsp_ready = 1'b0;
    cop_ready = 1'b0; cop_wait = 1'b0; cop_wr = 1'b0; cop_rd = '0;

    // Reset state
    #3;
    chk("rst_cop_valid", cop_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_cycles", rsp_cycles, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_cop_insn", cop_insn, 0);
    #19 rst_n = 1'b1;
    tick();

    // xori: 0x12345678 ^ 0x0F0F0F0F = 0x1D3B5977, 5-cycle responder
    do_op("xori", 32'h0C00000B, 32'h12345678, 32'h0F0F0F0F, 5, 32'h1D3B5977, 1'b1);
    rsp_handshake("xori");

    // addi: 0xFFFFFFFF + 2 = 0x00000001
    do_op("addi", 32'h0800000B, 32'hFFFFFFFF, 32'h00000002, 5, 32'h00000001, 1'b1);
    rsp_handshake("addi");

    // rdrand (funct3 = 010), 3-cycle responder, no rd write
    do_op("rdrand", 32'h0000200B, 32'h0, 32'h0, 3, 32'hA5A51234, 1'b0);
    rsp_handshake("rdrand");

    // Bad opcode: never on the bus, answered one cycle after accept
    req_valid = 1'b1; req_insn = 32'h0C000033; req_rs1 = 32'h1; req_rs2 = 32'h2;
    tick();
    req_valid = 1'b0;
    chk("badop_cop_valid", cop_valid, 0);
    chk("badop_rsp_valid", rsp_valid, 1);
    chk("badop_rsp_err", rsp_err, 2'b10);
    chk("badop_rsp_cycles", rsp_cycles, 0);
    chk("badop_rsp_data", rsp_data, 0);
    chk("badop_busy", busy, 1);
    rsp_handshake("badop");

    // Timeout: no cop_ready, cop_valid high exactly 16 cycles
    req_valid = 1'b1; req_insn = 32'h0C00000B; req_rs1 = 32'h5; req_rs2 = 32'h6;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("tmo_cop_valid", cop_valid, 1);
      chk("tmo_rsp_valid_low", rsp_valid, 0);
      cop_rd = $urandom; cop_wr = 1'b1;
      tick();
    end
    chk("tmo_cop_valid_off", cop_valid, 0);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_err", rsp_err, 2'b01);
    chk("tmo_rsp_data", rsp_data, 0);
    chk("tmo_rsp_wr", rsp_wr, 0);
    chk("tmo_rsp_cycles", rsp_cycles, 16);
    // Late cop_ready pulse three cycles on is ignored
    tick(); tick();
    cop_ready = 1'b1; cop_rd = 32'hDEADBEEF; cop_wr = 1'b1;
    tick();
    cop_ready = 1'b0;
    chk("late_rsp_err", rsp_err, 2'b01);
    chk("late_rsp_data", rsp_data, 0);
    chk("late_rsp_valid", rsp_valid, 1);
    chk("late_cop_valid", cop_valid, 0);
    rsp_handshake("tmo");

    // Next op completes normally, then its response is held back 10 cycles
    do_op("after_tmo", 32'h0800000B, 32'hFFFFFFFF, 32'h00000002, 5, 32'h00000001, 1'b1);
    req_valid = 1'b1; req_insn = 32'h0C00000B; req_rs1 = 32'hCAFE0000; req_rs2 = 32'h0000BABE;
    for (int k = 0; k < 10; k++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_data", rsp_data, 32'h00000001);
      chk("hold_rsp_err", rsp_err, 2'b00);
      chk("hold_rsp_cycles", rsp_cycles, 5);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_cop_valid", cop_valid, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", rsp_valid, 0);
    chk("hs_req_ready", req_ready, 1);
    chk("hs_cop_valid", cop_valid, 0);
    tick();
    req_valid = 1'b0;
    chk("next_cop_valid", cop_valid, 1);
    chk("next_cop_rs1", cop_rs1, 32'hCAFE0000);
    cop_ready = 1'b1; cop_rd = 32'hCAFEBABE; cop_wr = 1'b1;
    tick();
    cop_ready = 1'b0;
    chk("next_rsp_data", rsp_data, 32'hCAFEBABE);
    chk("next_rsp_cycles", rsp_cycles, 1);
    rsp_handshake("next");

    // Reset mid-ISSUE, between edges: outputs drop at once
    req_valid = 1'b1; req_insn = 32'h0C00000B; req_rs1 = 32'h7; req_rs2 = 32'h8;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_cop_valid", cop_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cop_valid", cop_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", req_ready, 1);
    cop_ready = 1'b1; cop_rd = 32'h12121212;
    tick();
    cop_ready = 1'b0;
    chk("post_rst_no_rsp", rsp_valid, 0);
    chk("post_rst_idle", busy, 0);
    tick();
    chk("post_rst_no_rsp2", rsp_valid, 0);

    do_op("final", 32'h0C00000B, 32'h0000FFFF, 32'hFFFF0000, 4, 32'hFFFFFFFF, 1'b1);
    rsp_handshake("final");

`ifdef COP_ISSUE_STATS_EN
    chk("stat_ops", stat_ops, 1);
    chk("stat_tmo", stat_tmo, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
